// File: rtl/anita4_trig_ctrl.sv
// Trigger controller for the ANITA4 SURF single-pol trigger latches: timestamps
// new triggers, reports them one at a time round-robin, then re-arms each latch.
module anita4_trig_ctrl #(
    parameter int NCH = 12,
    parameter int HW  = 8,
    parameter int TSW = 16,
    localparam int CW = $clog2(NCH)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NCH-1:0]  trig_sync_i,
    output logic [NCH-1:0]  ch_clr_o,
    output logic [NCH-1:0]  ch_mask_o,
    output logic [NCH-1:0]  ch_force_o,
    input  logic [NCH-1:0]  mask_i,
    input  logic            mask_wr_i,
    input  logic [NCH-1:0]  force_req_i,
    input  logic            force_stb_i,
    input  logic [HW-1:0]   holdoff_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CW-1:0]   evt_ch_o,
    output logic [TSW-1:0]  evt_time_o
);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        PENDING = 2'd1,
        HOLD    = 2'd2
    } ch_state_e;

    ch_state_e       st_q   [NCH];
    logic [HW-1:0]   hcnt_q [NCH];
    logic [TSW-1:0]  cts_q  [NCH];

    logic [TSW-1:0]  ts_q;
    logic [NCH-1:0]  tin_q;
    logic [NCH-1:0]  ch_clr_q;
    logic [NCH-1:0]  ch_mask_q;
    logic [NCH-1:0]  ch_force_q;
    logic            evt_valid_q;
    logic [CW-1:0]   evt_ch_q;
    logic [TSW-1:0]  evt_time_q;
    logic [CW-1:0]   rr_q;

    logic [NCH-1:0]  edge_w;
    logic [NCH-1:0]  pend_w;
    logic [NCH-1:0]  armed_w;
    logic            slot_free_w;
    logic            gnt_vld;
    logic [CW-1:0]   gnt_idx;
    logic [CW:0]     srch_idx;

    assign edge_w      = trig_sync_i & ~tin_q;
    assign slot_free_w = ~evt_valid_q | evt_ready_i;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pend_w[i]  = (st_q[i] == PENDING);
            armed_w[i] = (st_q[i] == ARMED);
        end
    end

    // Cyclic search starting just after rr_q, so the last winner is checked last.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = rr_q;
        srch_idx = '0;
        for (int k = 1; k <= NCH; k++) begin
            srch_idx = {1'b0, rr_q} + (CW+1)'(k);
            if (srch_idx >= (CW+1)'(NCH))
                srch_idx = srch_idx - (CW+1)'(NCH);
            if (!gnt_vld && pend_w[srch_idx[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = srch_idx[CW-1:0];
            end
        end
        if (!slot_free_w)
            gnt_vld = 1'b0;
    end

    // Reset parks every channel in HOLD with a zero count, so latches are cleared
    // during reset and all channels arm on the first clock after release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]   <= HOLD;
                hcnt_q[i] <= '0;
                cts_q[i]  <= '0;
            end
            ch_clr_q <= '1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (st_q[i])
                    ARMED: begin
                        if (edge_w[i] && !ch_mask_q[i]) begin
                            st_q[i]  <= PENDING;
                            cts_q[i] <= ts_q;
                        end
                    end
                    PENDING: begin
                        if (gnt_vld && (gnt_idx == CW'(i))) begin
                            st_q[i]     <= HOLD;
                            hcnt_q[i]   <= holdoff_i;
                            ch_clr_q[i] <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hcnt_q[i] == '0) begin
                            st_q[i]     <= ARMED;
                            ch_clr_q[i] <= 1'b0;
                        end else begin
                            hcnt_q[i] <= hcnt_q[i] - HW'(1);
                        end
                    end
                    default: begin
                        st_q[i]     <= HOLD;
                        hcnt_q[i]   <= '0;
                        ch_clr_q[i] <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_time_q  <= '0;
            rr_q        <= CW'(NCH-1);
        end else if (gnt_vld) begin
            evt_valid_q <= 1'b1;
            evt_ch_q    <= gnt_idx;
            evt_time_q  <= cts_q[gnt_idx];
            rr_q        <= gnt_idx;
        end else if (evt_valid_q && evt_ready_i) begin
            evt_valid_q <= 1'b0;
        end
    end

    // Force is qualified with the mask as it stands this cycle, before any write lands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts_q       <= '0;
            tin_q      <= '0;
            ch_mask_q  <= '1;
            ch_force_q <= '0;
        end else begin
            ts_q  <= ts_q + TSW'(1);
            tin_q <= trig_sync_i;
            if (mask_wr_i)
                ch_mask_q <= mask_i;
            ch_force_q <= force_stb_i ? (force_req_i & ~ch_mask_q & armed_w) : '0;
        end
    end

    assign ch_clr_o    = ch_clr_q;
    assign ch_mask_o   = ch_mask_q;
    assign ch_force_o  = ch_force_q;
    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;
    assign evt_time_o  = evt_time_q;

endmodule

// File: tb/tb_anita4_trig_ctrl.sv
// Self-checking bench for anita4_trig_ctrl: expected events are queued as triggers
// are driven and compared in order as the event port hands them over.
module tb_anita4_trig_ctrl;
    localparam int NCH = 12;
    localparam int HW  = 8;
    localparam int TSW = 16;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  trig_sync;
    logic [NCH-1:0]  ch_clr;
    logic [NCH-1:0]  ch_mask;
    logic [NCH-1:0]  ch_force;
    logic [NCH-1:0]  mask_in;
    logic            mask_wr;
    logic [NCH-1:0]  force_req;
    logic            force_stb;
    logic [HW-1:0]   holdoff;
    logic            evt_valid;
    logic            evt_ready;
    logic [CW-1:0]   evt_ch;
    logic [TSW-1:0]  evt_time;

    typedef struct {
        int ch;
        int tm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [TSW-1:0] tb_ts;

    anita4_trig_ctrl #(.NCH(NCH), .HW(HW), .TSW(TSW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .trig_sync_i (trig_sync),
        .ch_clr_o    (ch_clr),
        .ch_mask_o   (ch_mask),
        .ch_force_o  (ch_force),
        .mask_i      (mask_in),
        .mask_wr_i   (mask_wr),
        .force_req_i (force_req),
        .force_stb_i (force_stb),
        .holdoff_i   (holdoff),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_ch_o    (evt_ch),
        .evt_time_o  (evt_time)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_exp(input int ch);
        exp_t e;
        e.ch = ch;
        e.tm = int'(tb_ts);
        sb_q.push_back(e);
    endtask

    task automatic clear_mask();
        step();
        mask_wr = 1'b1;
        mask_in = '0;
        step();
        mask_wr = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        trig_sync = '0;
        sb_q.delete();
        repeat (3) step();
        rst_n = 1'b1;
        clear_mask();
    endtask

    task automatic test_reset();
        repeat (3) step();
        smp();
        n_cmp++;
        if (ch_clr !== '1 || evt_valid !== 1'b0 || evt_ch !== '0 || evt_time !== '0 ||
            ch_mask !== '1 || ch_force !== '0) begin
            n_mis++;
            $display("FAIL reset_values: clr=%h valid=%b ch=%0d time=%0d mask=%h force=%h, required clr=fff valid=0 ch=0 time=0 mask=fff force=000",
                     ch_clr, evt_valid, evt_ch, evt_time, ch_mask, ch_force);
        end
        step();
        rst_n = 1'b1;
        smp();
        n_cmp++;
        if (ch_clr !== '1) begin
            n_mis++;
            $display("FAIL reset_clr_cycle0: clr=%h, required fff", ch_clr);
        end
        step();
        smp();
        n_cmp++;
        if (ch_clr !== '0) begin
            n_mis++;
            $display("FAIL reset_clr_cycle1: clr=%h, required 000", ch_clr);
        end
        clear_mask();
        smp();
        n_cmp++;
        if (ch_mask !== '0) begin
            n_mis++;
            $display("FAIL mask_clear: mask=%h, required 000", ch_mask);
        end
    endtask

    task automatic test_single();
        int guard = 0;
        int clr_cnt = 0;
        exp_t e;
        step();
        while (tb_ts != 16'd100 && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++;
            n_mis++;
            $display("FAIL single_ts_wait: ts=%0d, required 100 within 300 cycles", tb_ts);
        end
        evt_ready = 1'b1;
        trig_sync = NCH'(1) << 3;
        push_exp(3);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) trig_sync = '0;
            end
            smp();
            if (ch_clr[3]) clr_cnt++;
            if (c < 2) begin
                n_cmp++;
                if (evt_valid !== 1'b0 || ch_clr[3] !== 1'b0) begin
                    n_mis++;
                    $display("FAIL single_early c=%0d: valid=%b clr3=%b, required 0 0", c, evt_valid, ch_clr[3]);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (evt_valid !== 1'b1 || ch_clr[3] !== 1'b1) begin
                    n_mis++;
                    $display("FAIL single_latency: valid=%b clr3=%b, required 1 1", evt_valid, ch_clr[3]);
                end
            end
            if (evt_valid && evt_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL single_evt: got ch=%0d with no event expected", evt_ch);
                end else begin
                    e = sb_q.pop_front();
                    if (evt_ch !== CW'(e.ch) || evt_time !== TSW'(e.tm)) begin
                        n_mis++;
                        $display("FAIL single_evt: got ch=%0d time=%0d, required ch=%0d time=%0d",
                                 evt_ch, evt_time, e.ch, e.tm);
                    end
                end
            end
        end
        n_cmp++;
        if (clr_cnt != 5 || sb_q.size() != 0) begin
            n_mis++;
            $display("FAIL single_clr_len: clr3 cycles=%0d left=%0d, required 5 and 0", clr_cnt, sb_q.size());
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        do_reset();
        step();
        evt_ready = 1'b1;
        trig_sync = (NCH'(1) << 0) | (NCH'(1) << 5) | (NCH'(1) << 11);
        push_exp(0);
        push_exp(5);
        push_exp(11);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) trig_sync = '0;
            end
            smp();
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if (evt_valid !== 1'b1) begin
                    n_mis++;
                    $display("FAIL simul_valid c=%0d: valid=%b, required 1", c, evt_valid);
                end
            end
            if (evt_valid && evt_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL simul_evt: got ch=%0d with no event expected", evt_ch);
                end else begin
                    e = sb_q.pop_front();
                    if (evt_ch !== CW'(e.ch) || evt_time !== TSW'(e.tm)) begin
                        n_mis++;
                        $display("FAIL simul_evt: got ch=%0d time=%0d, required ch=%0d time=%0d",
                                 evt_ch, evt_time, e.ch, e.tm);
                    end
                end
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_mis++;
            $display("FAIL simul_drain: %0d events left, required 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [TSW-1:0] t0;
        repeat (10) step();
        evt_ready = 1'b0;
        trig_sync = (NCH'(1) << 2) | (NCH'(1) << 7);
        t0 = tb_ts;
        push_exp(2);
        push_exp(7);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                step();
                if (c == 1)  trig_sync = '0;
                if (c == 12) evt_ready = 1'b1;
            end
            smp();
            if (c >= 2 && c <= 11) begin
                n_cmp++;
                if (evt_valid !== 1'b1 || evt_ch !== CW'(2) || evt_time !== t0 || ch_clr[7] !== 1'b0) begin
                    n_mis++;
                    $display("FAIL bp_hold c=%0d: valid=%b ch=%0d time=%0d clr7=%b, required 1 2 %0d 0",
                             c, evt_valid, evt_ch, evt_time, ch_clr[7], t0);
                end
            end
            if (c == 13) begin
                n_cmp++;
                if (evt_valid !== 1'b1 || evt_ch !== CW'(7)) begin
                    n_mis++;
                    $display("FAIL bp_release: valid=%b ch=%0d, required 1 7", evt_valid, evt_ch);
                end
            end
            if (evt_valid && evt_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL bp_evt: got ch=%0d with no event expected", evt_ch);
                end else begin
                    e = sb_q.pop_front();
                    if (evt_ch !== CW'(e.ch) || evt_time !== TSW'(e.tm)) begin
                        n_mis++;
                        $display("FAIL bp_evt: got ch=%0d time=%0d, required ch=%0d time=%0d",
                                 evt_ch, evt_time, e.ch, e.tm);
                    end
                end
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_mis++;
            $display("FAIL bp_drain: %0d events left, required 0", sb_q.size());
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        repeat (10) step();
        evt_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            step();
            if (r < 3) begin
                trig_sync = (NCH'(1) << 1) | (NCH'(1) << 4);
                push_exp(1);
                push_exp(4);
            end else begin
                trig_sync = (NCH'(1) << 1) | (NCH'(1) << 4) | (NCH'(1) << 11);
                push_exp(11);
                push_exp(1);
                push_exp(4);
            end
            for (int c = 0; c < 10; c++) begin
                if (c > 0) begin
                    step();
                    if (c == 1) trig_sync = '0;
                end
                smp();
                if (evt_valid && evt_ready) begin
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_mis++;
                        $display("FAIL rr_evt: got ch=%0d with no event expected", evt_ch);
                    end else begin
                        e = sb_q.pop_front();
                        if (evt_ch !== CW'(e.ch) || evt_time !== TSW'(e.tm)) begin
                            n_mis++;
                            $display("FAIL rr_evt round=%0d: got ch=%0d time=%0d, required ch=%0d time=%0d",
                                     r, evt_ch, evt_time, e.ch, e.tm);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_mis++;
            $display("FAIL rr_drain: %0d events left, required 0", sb_q.size());
        end
    endtask

    task automatic test_mask_force();
        logic bad = 1'b0;
        repeat (10) step();
        mask_wr = 1'b1;
        mask_in = NCH'(1) << 6;
        step();
        mask_wr = 1'b0;
        smp();
        n_cmp++;
        if (ch_mask !== (NCH'(1) << 6)) begin
            n_mis++;
            $display("FAIL mask_load: mask=%h, required 040", ch_mask);
        end
        step();
        trig_sync = NCH'(1) << 6;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) trig_sync = '0;
            end
            smp();
            if (evt_valid || ch_clr[6]) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_mis++;
            $display("FAIL masked_edge: event or clr6 seen=%b, required 0", bad);
        end
        step();
        force_stb = 1'b1;
        force_req = (NCH'(1) << 6) | (NCH'(1) << 8);
        step();
        force_stb = 1'b0;
        force_req = '0;
        smp();
        n_cmp++;
        if (ch_force !== (NCH'(1) << 8)) begin
            n_mis++;
            $display("FAIL force_pulse: force=%h, required 100", ch_force);
        end
        step();
        smp();
        n_cmp++;
        if (ch_force !== '0) begin
            n_mis++;
            $display("FAIL force_one_cycle: force=%h, required 000", ch_force);
        end
        step();
        mask_wr   = 1'b1;
        mask_in   = NCH'(1) << 8;
        force_stb = 1'b1;
        force_req = (NCH'(1) << 6) | (NCH'(1) << 8);
        step();
        mask_wr   = 1'b0;
        force_stb = 1'b0;
        force_req = '0;
        smp();
        n_cmp++;
        if (ch_force !== (NCH'(1) << 8) || ch_mask !== (NCH'(1) << 8)) begin
            n_mis++;
            $display("FAIL force_old_mask: force=%h mask=%h, required 100 100", ch_force, ch_mask);
        end
        clear_mask();
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        repeat (10) step();
        evt_ready = 1'b0;
        trig_sync = NCH'(1) << 5;
        push_exp(5);
        step();
        trig_sync = '0;
        step();
        trig_sync = NCH'(1) << 9;
        push_exp(9);
        step();
        trig_sync = '0;
        step();
        smp();
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_ch !== CW'(5)) begin
            n_mis++;
            $display("FAIL midrst_pre: valid=%b ch=%0d, required 1 5", evt_valid, evt_ch);
        end
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        n_cmp++;
        if (evt_valid !== 1'b0 || ch_clr !== '1 || ch_mask !== '1) begin
            n_mis++;
            $display("FAIL midrst_async: valid=%b clr=%h mask=%h, required 0 fff fff", evt_valid, ch_clr, ch_mask);
        end
        repeat (3) step();
        rst_n = 1'b1;
        clear_mask();
        evt_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            smp();
            if (evt_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || ch_clr !== '0) begin
            n_mis++;
            $display("FAIL midrst_after: event seen=%b clr=%h, required 0 000", seen, ch_clr);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        trig_sync = '0;
        mask_in   = '0;
        mask_wr   = 1'b0;
        force_req = '0;
        force_stb = 1'b0;
        holdoff   = 8'd4;
        evt_ready = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_round_robin();
        test_mask_force();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/anita4_trig_ctrl.md
# anita4_trig_ctrl

Per-polarisation trigger controller for the ANITA4 SURF single-channel trigger latches. It collects the synchronised one-shot outputs of NCH single-pol trigger channels and timestamps each new trigger. It reports triggers one at a time over a valid/ready event port with round-robin arbitration, then re-arms each reported channel by holding its clear for a programmable holdoff. It also owns the per-channel mask register and sequences software force-triggers into the channels.

## Interface
- NCH, 12: number of trigger channels served.
- HW, 8: width of holdoff count.
- TSW, 16: width of free-running timestamp.
- CW, $clog2(NCH): channel index width (derived).

- CLK  in  1  system clock, all logic on rising edge.
- RST_B  in  1  asynchronous active-low reset.
- TRIG_SYNC_IN  in  NCH  bit 0 of each channel's synchronised trigger output; a high level means the latch is set.
- CH_CLR  out  NCH  per-channel clear/re-arm to the trigger latch, active high.
- CH_MASK  out  NCH  per-channel mask, 1 = masked.
- CH_FORCE  out  NCH  per-channel force pulse, one cycle.
- MASK_IN  in  NCH  new mask value.
- MASK_WR  in  1  loads MASK_IN into CH_MASK.
- FORCE_REQ  in  NCH  channels to force.
- FORCE_STB  in  1  qualifies FORCE_REQ, one cycle.
- HOLDOFF  in  HW  extra clear cycles after grant.
- EVT_VALID  out  1  event register holds an event.
- EVT_READY  in  1  consumer accepts the event.
- EVT_CH  out  CW  channel index of the event.
- EVT_TIME  out  TSW  timestamp captured at trigger detection.

## Operation
- Timestamp counter TS: +1 every cycle, wraps 2^TSW-1 -> 0; reset 0.
- Edge detect: register TRIG_SYNC_IN into tin_d (reset 0). edge[i] = TRIG_SYNC_IN[i] & ~tin_d[i].
- Per-channel FSM, states ARMED, PENDING, HOLD:
  - ARMED: on edge[i] with CH_MASK[i]=0, capture TS into ts[i] and go to PENDING. Edges on masked channels are ignored.
  - PENDING: wait for a grant; on grant go to HOLD and load hcnt[i] = HOLDOFF.
  - HOLD: CH_CLR[i]=1. If hcnt[i]=0, go to ARMED; else decrement.
- CH_CLR[i] = 1 exactly while the channel is in HOLD, registered.
- Arbiter:
  - Slot is free when EVT_VALID=0, or EVT_VALID&EVT_READY in this cycle.
  - When the slot is free and any channel is PENDING, grant the first PENDING channel strictly after rr_ptr, searching cyclically; a channel equal to rr_ptr is considered last.
  - On grant: EVT_CH <- index, EVT_TIME <- ts[index], EVT_VALID <- 1, rr_ptr <- index.
  - One grant per cycle maximum.
- Event port:
  - EVT_VALID, EVT_CH and EVT_TIME are held stable until EVT_VALID&EVT_READY.
  - On that handshake with no new grant, EVT_VALID <- 0.
  - A handshake and a new grant in the same cycle reload the register back-to-back.
- Mask: MASK_WR loads CH_MASK next cycle. Masking a PENDING or HOLD channel does not cancel it; it completes normally.
- Force: on FORCE_STB, CH_FORCE <- FORCE_REQ & ~CH_MASK & armed for one cycle, then 0. Requests for unarmed or masked channels are dropped. The resulting TRIG_SYNC_IN edge is handled as a normal trigger.
- Simultaneous events:
  - MASK_WR and FORCE_STB in the same cycle: force uses the old mask.
  - An edge in a channel's HOLD exit cycle is ignored, because the channel is still HOLD that cycle.

## Timing
- Reset (RST_B low, async):
  - TS=0, tin_d=0, rr_ptr=NCH-1, EVT_VALID=0, EVT_CH=0, EVT_TIME=0, CH_MASK=all 1s, CH_FORCE=0.
  - All channels in HOLD with hcnt=0, so CH_CLR=all 1s during reset.
  - First clock after release: all channels go to ARMED, and CH_CLR=0 from cycle 1.
- Reset mid-operation immediately restores the values above; a pending event is lost.
- Latency: edge seen at cycle t gives PENDING at t+1. With the slot free, the grant is at t+1, EVT_VALID=1 at t+2, and CH_CLR[i]=1 from t+2 through t+2+HOLDOFF (HOLDOFF+1 cycles). ARMED at t+3+HOLDOFF.
- EVT_TIME equals the TS value in cycle t.
- Channel clear does not wait for the event handshake. Backpressure only delays the grant, so a channel stays PENDING and its latch stays set.

## Test plan
- Reset release with mask cleared by MASK_WR, MASK_IN=0: CH_CLR=all 1s until cycle 1, then 0. Rising edge on ch3 at TS=100 -> EVT_VALID at +2 with EVT_CH=3, EVT_TIME=100. CH_CLR[3] high for HOLDOFF+1=5 cycles with HOLDOFF=4.
- Simultaneous edges on ch0, ch5, ch11 with EVT_READY=1 and rr_ptr=NCH-1: events in order 0, 5, 11 on consecutive cycles, each keeping its own captured TS.
- EVT_READY=0 for 10 cycles with ch2 and ch7 pending: ch2 is held stable on the port and ch7 stays PENDING with CH_CLR[7]=0. Release ready -> ch7 event on the next cycle with its original timestamp.
- Round-robin fairness: ch1 and ch4 retrigger every time they are re-armed -> grants alternate 1, 4, 1, 4 and neither is starved.
- Masked ch6 edge -> no event, CH_CLR[6] stays 0. FORCE_STB with FORCE_REQ=ch6|ch8, ch6 masked -> CH_FORCE=ch8 only, for exactly one cycle.
- Assert RST_B low while ch9 is PENDING and an event is valid -> EVT_VALID drops immediately and CH_CLR=all 1s. After release, no event for ch9 unless a new edge occurs.
